// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Turns parallel words received over a valid/ready handshake into a serial
//   bit stream, one bit per enable strobe. It feeds the programmable sequence
//   detector. A shift register plus one holding word let back-to-back words
//   stream with no idle bit between them.
//
// Parameters
//   DATA_W      word width in bits (>= 2)
//   MSB_FIRST   1: bit DATA_W-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk           in   rising-edge clock
//   resetn        in   synchronous active-low reset
//   i_in_valid    in   i_in_data holds a word to transfer
//   o_in_ready    out  a word can be accepted this cycle
//   i_in_data     in   parallel word
//   i_en          in   bit strobe; a bit is consumed only while high
//   o_dout        out  current serial bit (0 when the shifter is empty)
//   o_dout_valid  out  o_dout is consumed this cycle
//   o_busy        out  shifter or holding register occupied
//   o_word_done   out  one-cycle pulse when the last bit of a word is consumed
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int DATA_W    = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_en,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_busy,
    output logic              o_word_done
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    // IDLE: shifter empty; SHIFT: shifter loaded, hold empty; FULL: both loaded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_hold;
    logic [CNT_W-1:0]   r_cnt;

    logic w_act;
    logic w_hold_full;
    logic w_accept;
    logic w_last;
    logic w_load_in;      // shifter <= i_in_data
    logic w_load_hold;    // shifter <= r_hold
    logic w_shift;        // consume one bit, keep going
    logic w_drain;        // last bit consumed, nothing follows
    logic w_capture;      // r_hold <= i_in_data

    // Move the next bit toward the output end, zero-filling behind it.
    function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
        if (MSB_FIRST)
            return {v[DATA_W-2:0], 1'b0};
        else
            return {1'b0, v[DATA_W-1:1]};
    endfunction

    assign w_act        = (r_state != ST_IDLE);
    assign w_hold_full  = (r_state == ST_FULL);
    assign o_in_ready   = ~w_hold_full & resetn;
    assign w_accept     = i_in_valid & o_in_ready;
    assign o_dout_valid = w_act & i_en;
    assign w_last       = (r_cnt == LAST_CNT);
    assign o_word_done  = o_dout_valid & w_last;
    assign o_busy       = w_act;
    assign o_dout       = w_act & (MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0]);

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and datapath controls. In FULL the input is not ready, so a
    // hold->shifter move never coincides with a new accept.
    always_comb begin
        w_state_nxt = r_state;
        w_load_in   = 1'b0;
        w_load_hold = 1'b0;
        w_shift     = 1'b0;
        w_drain     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load_in   = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (o_dout_valid && w_last) begin
                    if (w_accept) begin
                        w_load_in = 1'b1;
                    end else begin
                        w_drain     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_shift = o_dout_valid;
                    if (w_accept) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (o_dout_valid && w_last) begin
                    w_load_hold = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_shift = o_dout_valid;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shift <= '0;
            r_hold  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_load_in) begin
                r_shift <= i_in_data;
                r_cnt   <= '0;
            end else if (w_load_hold) begin
                r_shift <= r_hold;
                r_cnt   <= '0;
            end else if (w_drain) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift) begin
                r_shift <= shift_one(r_shift);
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_capture)
                r_hold <= i_in_data;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Two serializers (MSB-first and LSB-first) share one input stream. Every
//   accepted word is expanded into its expected bit sequence and appended to
//   scoreboard queues; the monitor walks those queues as bits are consumed.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          en = 1'b0;

    logic in_ready, dout, dout_valid, busy, word_done;
    logic in_ready_l, dout_l, dout_valid_l, busy_l, word_done_l;

    bit exp_m[$];     // expected bits, MSB-first order
    bit exp_l[$];     // expected bits, LSB-first order
    bit exp_last[$];  // bit closes a word
    int rd_idx = 0;   // next bit to be consumed
    int pend   = 0;   // bits pushed for an accept still to happen at the next edge
    int n_cmp  = 0;
    int n_bad  = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .resetn(resetn),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .i_en(en), .o_dout(dout), .o_dout_valid(dout_valid),
        .o_busy(busy), .o_word_done(word_done)
    );

    bit_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .resetn(resetn),
        .i_in_valid(in_valid), .o_in_ready(in_ready_l), .i_in_data(in_data),
        .i_en(en), .o_dout(dout_l), .o_dout_valid(dout_valid_l),
        .o_busy(busy_l), .o_word_done(word_done_l)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are sampled at the falling edge, between input updates.
    always @(negedge clk) begin
        int o;
        bit ev;
        bit em;
        bit el;
        bit ek;
        if (!resetn) begin
            chk("in_ready_rst", in_ready, 1'b0);
            chk("in_ready_rst_l", in_ready_l, 1'b0);
            rd_idx = exp_m.size();   // anything in flight is discarded
        end else begin
            o  = exp_m.size() - pend - rd_idx;
            em = (o > 0) ? exp_m[rd_idx] : 1'b0;
            el = (o > 0) ? exp_l[rd_idx] : 1'b0;
            ek = (o > 0) ? exp_last[rd_idx] : 1'b0;
            ev = (o > 0) && en;
            chk("dout", dout, em);
            chk("dout_l", dout_l, el);
            chk("dout_valid", dout_valid, ev);
            chk("dout_valid_l", dout_valid_l, ev);
            chk("busy", busy, o > 0);
            chk("busy_l", busy_l, o > 0);
            chk("in_ready", in_ready, o <= DW);
            chk("in_ready_l", in_ready_l, o <= DW);
            chk("word_done", word_done, ev && ek);
            chk("word_done_l", word_done_l, ev && ek);
            if (ev)
                rd_idx++;
        end
    end

    // One clock of stimulus. The word is queued only if the reference view of
    // the block (at most one word beyond the shifter) says it can be taken.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic e, input logic rn);
        int o;
        @(posedge clk);
        #1;
        resetn   = rn;
        in_valid = v;
        in_data  = d;
        en       = e;
        o = exp_m.size() - rd_idx;
        if (v && rn && o <= DW) begin
            for (int i = 0; i < DW; i++) begin
                exp_m.push_back(d[DW-1-i]);
                exp_l.push_back(d[i]);
                exp_last.push_back(i == DW - 1);
            end
            pend = DW;
        end else begin
            pend = 0;
        end
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, e, 1'b1);
    endtask

    initial begin
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        idle(2, 1'b1);

        // single word from idle
        step(1'b1, 5'b10110, 1'b1, 1'b1);
        idle(7, 1'b1);

        // back-to-back words, third word offered while full
        step(1'b1, 5'b11001, 1'b1, 1'b1);
        step(1'b1, 5'b00111, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 5'b10001, 1'b1, 1'b1);
        idle(12, 1'b1);

        // LSB-first ordering checked through the second instance
        step(1'b1, 5'b00011, 1'b1, 1'b1);
        idle(7, 1'b1);

        // gappy strobe
        step(1'b1, 5'b10101, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(6, 1'b1);

        // reset mid-word with the hold register full
        step(1'b1, 5'b11111, 1'b1, 1'b1);
        step(1'b1, 5'b10011, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 5'b01010, 1'b1, 1'b1);
        idle(7, 1'b1);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++)
            step(1'($urandom_range(0, 1)), DW'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) != 0));
        idle(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
